// File: rtl/wmem_rd_ctrl.sv
// wmem_rd_ctrl: reads a run of consecutive rows from the weight memory and
// streams them out through a valid/ready port.
//
// The memory returns data one cycle after the address is issued, and it cannot
// serve a read while its write port is busy. Each read that is issued lands in a
// small 3-entry FIFO. Reads are throttled so that every row in flight always has
// a FIFO slot waiting for it, which means a stalled consumer can never cause an
// overflow.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_start           start a job with i_base_addr / i_row_cnt (ignored when busy)
//   i_wr_busy         memory write port active; no read may be issued this cycle
//   o_mem_rd_en/addr  memory read request; data returns on i_mem_rd_data next cycle
//   o_row_*           output row stream; o_row_last tags the final row of the job
//   i_row_ready       consumer ready
//   o_busy            job in progress (RUN or DRAIN)
//   o_done            one-cycle pulse at job completion
module wmem_rd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ROW_NUM       = 6,
  parameter int ADDR_WIDTH    = 7,
  parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  input  logic [ADDR_WIDTH-1:0]    i_row_cnt,
  input  logic                     i_wr_busy,
  output logic                     o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    o_mem_rd_addr,
  input  logic [ROW_WGT_WIDTH-1:0] i_mem_rd_data,
  output logic [ROW_WGT_WIDTH-1:0] o_row_data,
  output logic                     o_row_valid,
  input  logic                     i_row_ready,
  output logic                     o_row_last,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]               state_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [ADDR_WIDTH-1:0]    rem_q;        // reads still to issue
  logic                     pend_q;       // read issued last cycle, data on the bus now
  logic                     pend_last_q;  // that read was the job's final row
  logic [ROW_WGT_WIDTH-1:0] fifo_data [3];
  logic [2:0]               fifo_last;
  logic [1:0]               wr_ptr, rd_ptr, fifo_cnt;
  logic                     done_q;

  logic push, pop, drain_done, rem_one;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Outstanding rows (stored + in flight) must stay below the FIFO depth
  // before another read may be issued.
  assign o_mem_rd_en   = (state_q == S_RUN) && !i_wr_busy &&
                         ({1'b0, fifo_cnt} + {2'b00, pend_q} < 3'd3);
  assign o_mem_rd_addr = addr_q;

  assign push    = pend_q;
  assign pop     = (fifo_cnt != 2'd0) && i_row_ready;
  assign rem_one = (rem_q == ADDR_WIDTH'(1));

  // No more reads will arrive in DRAIN. Once nothing is in flight and the
  // FIFO empties this cycle, the job is finished. Finishing here lets o_done
  // appear in the cycle right after the final handshake.
  assign drain_done = (state_q == S_DRAIN) && !pend_q &&
                      ((fifo_cnt == 2'd0) || (fifo_cnt == 2'd1 && pop));

  assign o_row_valid = (fifo_cnt != 2'd0);
  assign o_row_data  = fifo_data[rd_ptr];
  assign o_row_last  = fifo_last[rd_ptr] && o_row_valid;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pend_q      <= o_mem_rd_en;
      pend_last_q <= o_mem_rd_en && rem_one;
      done_q      <= drain_done ||
                     (state_q == S_IDLE && i_start && i_row_cnt == '0);
      case (state_q)
        S_IDLE: begin
          if (i_start && i_row_cnt != '0) begin
            addr_q  <= i_base_addr;
            rem_q   <= i_row_cnt;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (o_mem_rd_en) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);  // wraps naturally at 2^ADDR_WIDTH
            rem_q  <= rem_q - ADDR_WIDTH'(1);
            if (rem_one) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) fifo_data[i] <= '0;
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= i_mem_rd_data;
        fifo_last[wr_ptr] <= pend_last_q;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
